// File: rtl/relm_fifo_mc_io.sv
// Multi-channel FIFO bridge between ReLM PUSH ports and POP ports.
// Each channel is an independent first-word-fall-through FIFO with status, peek and clear commands.
module relm_fifo_mc_io #(
  parameter int NCH   = 2,
  parameter int WAD   = 4,
  parameter int WD    = 32,
  parameter int AFULL = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*(WD+1)-1:0] push_d,
  output logic [NCH-1:0]        push_retry,
  input  logic [NCH*(WD+1)-1:0] pop_d,
  output logic [NCH*(WD+1)-1:0] pop_q
);

  localparam int             DEPTH   = 1 << WAD;
  localparam logic [WAD:0]   DEPTH_C = {1'b1, {WAD{1'b0}}};
  localparam logic [WAD:0]   AFULL_C = (WAD+1)'(AFULL);
  localparam logic [1:0]     CMD_STATUS = 2'b00;
  localparam logic [1:0]     CMD_POP    = 2'b01;
  localparam logic [1:0]     CMD_PEEK   = 2'b10;
  localparam logic [1:0]     CMD_CLEAR  = 2'b11;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WD-1:0]  mem_q [DEPTH];
    logic [WAD-1:0] rd_q, rd_d;
    logic [WAD-1:0] wr_q, wr_d;
    logic [WAD:0]   cnt_q, cnt_d;

    logic           push_v_s;
    logic [WD-1:0]  push_data_s;
    logic           cmd_v_s;
    logic [1:0]     cmd_s;
    logic           cmd_unused_s;
    logic           empty_s, full_s, afull_s;
    logic           pop_ok_s, clr_s, push_rty_s, push_ok_s;
    logic [WD-1:0]  status_s;
    logic [WD-1:0]  head_s;
    logic [WD:0]    pop_word_s;

    assign push_v_s     = push_d[c*(WD+1)+WD];
    assign push_data_s  = push_d[c*(WD+1) +: WD];
    assign cmd_v_s      = pop_d[c*(WD+1)+WD];
    assign cmd_s        = pop_d[c*(WD+1) +: 2];
    assign cmd_unused_s = ^pop_d[c*(WD+1)+2 +: WD-2];

    assign empty_s = (cnt_q == {(WAD+1){1'b0}});
    assign full_s  = (cnt_q == DEPTH_C);
    assign afull_s = (cnt_q >= AFULL_C);
    assign head_s  = mem_q[rd_q];

    // A pop that would remove a word frees a slot in the same cycle, so a full channel can still accept.
    assign pop_ok_s   = cmd_v_s & (cmd_s == CMD_POP) & ~empty_s;
    assign clr_s      = cmd_v_s & (cmd_s == CMD_CLEAR);
    assign push_rty_s = push_v_s & (clr_s | (full_s & ~pop_ok_s));
    assign push_ok_s  = push_v_s & ~push_rty_s;

    // Status word layout: flags in the top bits, occupancy in the low bits.
    always_comb begin
      status_s           = {WD{1'b0}};
      status_s[WAD:0]    = cnt_q;
      status_s[WD-1]     = empty_s;
      status_s[WD-2]     = full_s;
      status_s[WD-3]     = afull_s;
    end

    // POP-port response, forced to zero while reset is asserted.
    always_comb begin
      pop_word_s = {(WD+1){1'b0}};
      if (!rst_n) begin
        pop_word_s = {(WD+1){1'b0}};
      end else if (cmd_v_s) begin
        case (cmd_s)
          CMD_STATUS, CMD_CLEAR: pop_word_s = {1'b0, status_s};
          CMD_POP, CMD_PEEK: begin
            if (empty_s) begin
              pop_word_s = {1'b1, {WD{1'b0}}};
            end else begin
              pop_word_s = {1'b0, head_s};
            end
          end
          default: pop_word_s = {(WD+1){1'b0}};
        endcase
      end else begin
        pop_word_s = {(WD+1){1'b0}};
      end
    end

    assign pop_q[c*(WD+1) +: WD+1] = pop_word_s;
    assign push_retry[c]           = rst_n & push_rty_s;

    // Pointer and occupancy update; clear overrides any concurrent push or pop.
    always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (clr_s) begin
        rd_d  = {WAD{1'b0}};
        wr_d  = {WAD{1'b0}};
        cnt_d = {(WAD+1){1'b0}};
      end else begin
        if (push_ok_s) begin
          wr_d = wr_q + WAD'(1);
        end else begin
          wr_d = wr_q;
        end
        if (pop_ok_s) begin
          rd_d = rd_q + WAD'(1);
        end else begin
          rd_d = rd_q;
        end
        cnt_d = cnt_q + (WAD+1)'(push_ok_s) - (WAD+1)'(pop_ok_s);
      end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q  <= {WAD{1'b0}};
        wr_q  <= {WAD{1'b0}};
        cnt_q <= {(WAD+1){1'b0}};
      end else begin
        rd_q  <= rd_d;
        wr_q  <= wr_d;
        cnt_q <= cnt_d;
      end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
      if (push_ok_s) begin
        mem_q[wr_q] <= push_data_s;
      end
    end
  end

endmodule
